// File: rtl/isp_tpg_source.sv
// Test-pattern video source: frame timing plus bars/ramp/solid/checker RGB on a
// vsync/hsync/den stream. Outputs are registered one clock behind the counters.
module isp_tpg_source #(
  parameter int unsigned source_h = 1024,
  parameter int unsigned source_v = 1024,
  parameter int unsigned h_blank  = 64,
  parameter int unsigned v_blank  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        out_vsync,
  output logic        out_hsync,
  output logic        out_den,
  output logic [7:0]  out_data_R,
  output logic [7:0]  out_data_G,
  output logic [7:0]  out_data_B,
  output logic        frame_start
);

  localparam int unsigned HTot = source_h + h_blank;
  localparam int unsigned VTot = source_v + v_blank;
  localparam int unsigned HW   = ($clog2(HTot) > 8) ? $clog2(HTot) : 8;
  localparam int unsigned VW   = ($clog2(VTot) > 8) ? $clog2(VTot) : 8;
  localparam int unsigned BarW = source_h / 8;
  localparam int unsigned BW   = ($clog2(BarW) > 0) ? $clog2(BarW) : 1;

  localparam logic [HW-1:0] HMax   = HW'(HTot - 1);
  localparam logic [VW-1:0] VMax   = VW'(VTot - 1);
  localparam logic [HW-1:0] HAct   = HW'(source_h);
  localparam logic [VW-1:0] VAct   = VW'(source_v);
  localparam logic [BW-1:0] BarMax = BW'(BarW - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [BW-1:0] bar_px_q, bar_px_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [1:0]    mode_q;
  logic [23:0]   solid_q;

  logic        run, h_last, v_last, frame_first, active, vs_act;
  logic [1:0]  eff_mode;
  logic [23:0] eff_solid, pix;
  logic [7:0]  ramp_b, chk;

  assign run         = (state_q == StRun);
  assign h_last      = (h_cnt_q == HMax);
  assign v_last      = (v_cnt_q == VMax);
  assign frame_first = run && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign vs_act      = run && (v_cnt_q < VAct);
  assign active      = vs_act && (h_cnt_q < HAct);

  // The first pixel of a frame must already use the values being latched.
  assign eff_mode  = frame_first ? mode : mode_q;
  assign eff_solid = frame_first ? solid_rgb : solid_q;

  always_comb begin
    state_d   = state_q;
    h_cnt_d   = '0;
    v_cnt_d   = '0;
    bar_px_d  = '0;
    bar_idx_d = '0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (h_last) begin
          v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
          if (v_last && !enable) state_d = StIdle;
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
          v_cnt_d = v_cnt_q;
          if (bar_px_q == BarMax) begin
            bar_idx_d = bar_idx_q + 1'b1;
          end else begin
            bar_px_d  = bar_px_q + 1'b1;
            bar_idx_d = bar_idx_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ramp_b = h_cnt_q[7:0] + v_cnt_q[7:0];
  assign chk    = (h_cnt_q[5] ^ v_cnt_q[5]) ? 8'd192 : 8'd64;

  always_comb begin
    pix = '0;
    unique case (eff_mode)
      // Bar colours fall out of the index bits: R=~b1, G=~b2, B=~b0.
      2'd0: pix = {{8{~bar_idx_q[1]}}, {8{~bar_idx_q[2]}}, {8{~bar_idx_q[0]}}};
      2'd1: pix = {h_cnt_q[7:0], v_cnt_q[7:0], ramp_b};
      2'd2: pix = eff_solid;
      2'd3: pix = {chk, chk, chk};
      default: pix = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      mode_q    <= '0;
      solid_q   <= '0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      if (frame_first) begin
        mode_q  <= mode;
        solid_q <= solid_rgb;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vsync   <= 1'b0;
      out_hsync   <= 1'b0;
      frame_start <= 1'b0;
      out_data_R  <= '0;
      out_data_G  <= '0;
      out_data_B  <= '0;
    end else begin
      out_vsync   <= vs_act;
      out_hsync   <= active;
      frame_start <= frame_first;
      {out_data_R, out_data_G, out_data_B} <= active ? pix : 24'h0;
    end
  end

  assign out_den = out_hsync;

endmodule
